// File: rtl/axis_pkg.sv
// Shared constants and types for the AXI-stream style datapath blocks.
// Holds the complex multiplier defaults and its internal mode encoding.
package axis_pkg;

  // Shortest pipeline the complex multiplier can be built with:
  // products, sum/difference, round/narrow.
  localparam int CMULT_MIN_PIPE = 3;

  // Default geometry of complex_int_mult_axis (Q1.15 x Q1.15 -> Q1.15).
  localparam int CMULT_A_W      = 16;
  localparam int CMULT_B_W      = 16;
  localparam int CMULT_OUT_W    = 16;
  localparam int CMULT_SHIFT    = 15;
  localparam int CMULT_PIPE_NUM = 4;

  // Per-sample multiply mode, decoded from s_conj.
  typedef enum logic {
    CMULT_NORM = 1'b0,
    CMULT_CONJ = 1'b1
  } cmult_mode_t;

endpackage

// File: rtl/cmult_round_sat.sv
// Round-half-up scaling and narrowing of one complex component.
// Purely combinational. With COMPLEX_MULT_SAT_EN defined the result
// saturates and o_sat reports clipping; otherwise the low OUT_W bits are
// kept (wrap) and the o_sat port does not exist.
module cmult_round_sat #(
  parameter int IN_W  = 33,
  parameter int OUT_W = 16,
  parameter int SHIFT = 15
) (
  input  logic signed [IN_W-1:0]  i_x,
  output logic signed [OUT_W-1:0] o_y
`ifdef COMPLEX_MULT_SAT_EN
  ,
  output logic                    o_sat
`endif
);

  // One guard bit so the rounding add can never overflow.
  localparam int RW = IN_W + 1;

  logic signed [RW-1:0] w_ext;
  logic signed [RW-1:0] w_rnd;

  assign w_ext = {i_x[IN_W-1], i_x};

  generate
    if (SHIFT > 0) begin : g_rnd
      localparam logic signed [RW-1:0] HALF = RW'(1) << (SHIFT - 1);
      // Add half an LSB of the output, then floor: ties go toward +inf.
      assign w_rnd = (w_ext + HALF) >>> SHIFT;
    end else begin : g_pass
      assign w_rnd = w_ext;
    end

    if (OUT_W >= RW) begin : g_widen
      // Output is wide enough for any rounded value: sign-extend only.
      assign o_y = OUT_W'(w_rnd);
`ifdef COMPLEX_MULT_SAT_EN
      assign o_sat = 1'b0;
`endif
    end else begin : g_narrow
`ifdef COMPLEX_MULT_SAT_EN
      localparam logic signed [OUT_W-1:0] Y_MAX = {1'b0, {(OUT_W-1){1'b1}}};
      localparam logic signed [OUT_W-1:0] Y_MIN = {1'b1, {(OUT_W-1){1'b0}}};
      logic w_ovf;
      // Fits only if every dropped bit equals the new sign bit.
      assign w_ovf = ~((&w_rnd[RW-1:OUT_W-1]) | ~(|w_rnd[RW-1:OUT_W-1]));
      assign o_y   = w_ovf ? (w_rnd[RW-1] ? Y_MIN : Y_MAX) : w_rnd[OUT_W-1:0];
      assign o_sat = w_ovf;
`else
      logic w_unused_hi;
      // Wrap: upper bits are intentionally discarded.
      assign w_unused_hi = ^w_rnd[RW-1:OUT_W];
      assign o_y         = w_rnd[OUT_W-1:0];
`endif
    end
  endgenerate

endmodule

// File: rtl/complex_int_mult_axis.sv
// Pipelined complex integer multiplier z = a*b or a*conj(b) with
// valid/ready flow control and a sideband last flag.
// Stage 1: four products. Stage 2: sum/difference. Stage 3: round and
// narrow. Stages 4..PIPE_NUM: delay. Whole pipe advances together.
// Optional: COMPLEX_MULT_SAT_EN selects saturation and adds sat_flag.
module complex_int_mult_axis
  import axis_pkg::*;
#(
  parameter int A_W      = CMULT_A_W,
  parameter int B_W      = CMULT_B_W,
  parameter int OUT_W    = CMULT_OUT_W,
  parameter int SHIFT    = CMULT_SHIFT,
  parameter int PIPE_NUM = CMULT_PIPE_NUM   // must be >= CMULT_MIN_PIPE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic                    s_last,
  input  logic                    s_conj,
  input  logic signed [A_W-1:0]   a_re,
  input  logic signed [A_W-1:0]   a_im,
  input  logic signed [B_W-1:0]   b_re,
  input  logic signed [B_W-1:0]   b_im,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_last,
  output logic signed [OUT_W-1:0] z_re,
  output logic signed [OUT_W-1:0] z_im
`ifdef COMPLEX_MULT_SAT_EN
  ,
  output logic                    sat_flag
`endif
);

  localparam int PR_W = A_W + B_W;
  localparam int P_W  = PR_W + 1;

  logic                    w_adv;
  logic                    w_acc;
  cmult_mode_t             w_mode_in;

  logic [PIPE_NUM:1]       r_vld_pipe;
  logic [PIPE_NUM:1]       r_last_pipe;

  cmult_mode_t             r_mode1;
  logic signed [PR_W-1:0]  r_p_rr, r_p_ii, r_p_ri, r_p_ir;

  logic signed [P_W-1:0]   w_re2, w_im2;
  logic signed [P_W-1:0]   r_re2, r_im2;

  logic signed [OUT_W-1:0] w_zre3, w_zim3;
  logic signed [OUT_W-1:0] r_zre [PIPE_NUM:3];
  logic signed [OUT_W-1:0] r_zim [PIPE_NUM:3];

  // Pipe moves when the output slot is empty or being drained; s_ready
  // depends only on the output side, never on s_valid.
  assign w_adv     = ~m_valid | m_ready;
  assign s_ready   = w_adv;
  assign w_acc     = s_valid & s_ready;
  assign w_mode_in = s_conj ? CMULT_CONJ : CMULT_NORM;

  // Valid and last shift registers; reset drops every in-flight sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe  <= '0;
      r_last_pipe <= '0;
    end else if (w_adv) begin
      r_vld_pipe  <= {r_vld_pipe[PIPE_NUM-1:1], w_acc};
      r_last_pipe <= {r_last_pipe[PIPE_NUM-1:1], s_last};
    end
  end

  // Stage 1: full-precision partial products plus the sample's mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p_rr  <= '0;
      r_p_ii  <= '0;
      r_p_ri  <= '0;
      r_p_ir  <= '0;
      r_mode1 <= CMULT_NORM;
    end else if (w_adv) begin
      r_p_rr  <= PR_W'(a_re) * PR_W'(b_re);
      r_p_ii  <= PR_W'(a_im) * PR_W'(b_im);
      r_p_ri  <= PR_W'(a_re) * PR_W'(b_im);
      r_p_ir  <= PR_W'(a_im) * PR_W'(b_re);
      r_mode1 <= w_mode_in;
    end
  end

  // Stage 2 combine: conj(b) flips the sign of the bi terms.
  always_comb begin
    w_re2 = '0;
    w_im2 = '0;
    if (r_mode1 == CMULT_CONJ) begin
      w_re2 = P_W'(r_p_rr) + P_W'(r_p_ii);
      w_im2 = P_W'(r_p_ir) - P_W'(r_p_ri);
    end else begin
      w_re2 = P_W'(r_p_rr) - P_W'(r_p_ii);
      w_im2 = P_W'(r_p_ri) + P_W'(r_p_ir);
    end
  end

  // Stage 2 register: one extra bit so sum/difference cannot overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_re2 <= '0;
      r_im2 <= '0;
    end else if (w_adv) begin
      r_re2 <= w_re2;
      r_im2 <= w_im2;
    end
  end

`ifdef COMPLEX_MULT_SAT_EN
  logic                w_sat_re, w_sat_im;
  logic [PIPE_NUM:3]   r_sat_pipe;
`endif

  cmult_round_sat #(.IN_W(P_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_rs_re (
    .i_x   (r_re2),
    .o_y   (w_zre3)
`ifdef COMPLEX_MULT_SAT_EN
    ,
    .o_sat (w_sat_re)
`endif
  );

  cmult_round_sat #(.IN_W(P_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_rs_im (
    .i_x   (r_im2),
    .o_y   (w_zim3)
`ifdef COMPLEX_MULT_SAT_EN
    ,
    .o_sat (w_sat_im)
`endif
  );

  // Stage 3 result register followed by pure delay up to PIPE_NUM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 3; k <= PIPE_NUM; k++) begin
        r_zre[k] <= '0;
        r_zim[k] <= '0;
      end
    end else if (w_adv) begin
      r_zre[3] <= w_zre3;
      r_zim[3] <= w_zim3;
      for (int k = 4; k <= PIPE_NUM; k++) begin
        r_zre[k] <= r_zre[k-1];
        r_zim[k] <= r_zim[k-1];
      end
    end
  end

`ifdef COMPLEX_MULT_SAT_EN
  // Clip indication delayed alongside its result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sat_pipe <= '0;
    end else if (w_adv) begin
      r_sat_pipe <= {r_sat_pipe[PIPE_NUM-1:3], w_sat_re | w_sat_im};
    end
  end

  assign sat_flag = r_sat_pipe[PIPE_NUM];
`endif

  assign m_valid = r_vld_pipe[PIPE_NUM];
  assign m_last  = r_last_pipe[PIPE_NUM];
  assign z_re    = r_zre[PIPE_NUM];
  assign z_im    = r_zim[PIPE_NUM];

endmodule

// File: tb/tb_complex_int_mult_axis.sv
// Bench for complex_int_mult_axis. Three instances share one input
// stream: default (16/16/16, SHIFT 15), wide exact (OUT_W 34, SHIFT 0) and
// half-scale (OUT_W 33, SHIFT 1). A queue-based reference model predicts
// every output; a directed table covers the worked examples.
module tb_complex_int_mult_axis;

`ifdef COMPLEX_MULT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic s_valid, s_last, s_conj, m_ready;
  logic signed [15:0] a_re, a_im, b_re, b_im;

  logic s_ready, m_valid, m_last;
  logic signed [15:0] z16_re, z16_im;
  logic s_ready34, m_valid34, m_last34;
  logic signed [33:0] z34_re, z34_im;
  logic s_ready33, m_valid33, m_last33;
  logic signed [32:0] z33_re, z33_im;
`ifdef COMPLEX_MULT_SAT_EN
  logic sat16, sat34, sat33;
`endif

  always #5 clk = ~clk;

  complex_int_mult_axis dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_last(s_last), .s_conj(s_conj),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .z_re(z16_re), .z_im(z16_im)
`ifdef COMPLEX_MULT_SAT_EN
    , .sat_flag(sat16)
`endif
  );

  complex_int_mult_axis #(.OUT_W(34), .SHIFT(0)) dut34 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready34),
    .s_last(s_last), .s_conj(s_conj),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .m_valid(m_valid34), .m_ready(m_ready), .m_last(m_last34),
    .z_re(z34_re), .z_im(z34_im)
`ifdef COMPLEX_MULT_SAT_EN
    , .sat_flag(sat34)
`endif
  );

  complex_int_mult_axis #(.OUT_W(33), .SHIFT(1)) dut33 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready33),
    .s_last(s_last), .s_conj(s_conj),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .m_valid(m_valid33), .m_ready(m_ready), .m_last(m_last33),
    .z_re(z33_re), .z_im(z33_im)
`ifdef COMPLEX_MULT_SAT_EN
    , .sat_flag(sat33)
`endif
  );

  typedef struct {
    longint re16, im16, re34, im34, re33, im33;
    bit     last;
    bit     sat;
  } exp_t;

  typedef struct {
    int     sel;            // 0: default, 1: OUT_W 34, 2: OUT_W 33
    longint ar, ai, br, bi;
    bit     conj;
    longint er, ei;
    bit     es;
  } dvec_t;

  int     checks = 0, failures = 0;
  int     cyc = 0, out_cnt = 0;
  exp_t   sbq[$];
  dvec_t  dt[7];
  bit     dir_on = 1'b0;
  int     dir_idx = 0;
  int     out_cyc[7];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scale, round half up, then saturate or wrap to ow bits.
  function automatic longint scale(input longint x, input int sh, input int ow,
                                   output bit clip);
    longint r, lo, hi, m;
    r = x;
    if (sh > 0) r = (x + (longint'(1) << (sh - 1))) >>> sh;
    lo = -(longint'(1) << (ow - 1));
    hi = (longint'(1) << (ow - 1)) - 1;
    clip = (r < lo) || (r > hi);
    if (SAT) begin
      if (r < lo) r = lo;
      else if (r > hi) r = hi;
    end else begin
      m = r & ((longint'(1) << ow) - 1);
      if (m > hi) m = m - (longint'(1) << ow);
      r = m;
    end
    return r;
  endfunction

  function automatic exp_t model(input longint ar, ai, br, bi, input bit cj, input bit lst);
    exp_t   e;
    longint re, im;
    bit     c0, c1, d;
    re = cj ? (ar * br + ai * bi) : (ar * br - ai * bi);
    im = cj ? (ai * br - ar * bi) : (ar * bi + ai * br);
    e.re16 = scale(re, 15, 16, c0);
    e.im16 = scale(im, 15, 16, c1);
    e.sat  = c0 | c1;
    e.re34 = scale(re, 0, 34, d);
    e.im34 = scale(im, 0, 34, d);
    e.re33 = scale(re, 1, 33, d);
    e.im33 = scale(im, 1, 33, d);
    e.last = lst;
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: scoreboard against the model, plus directed table.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sbq.delete();
    end else begin
      if (m_valid && m_ready) begin
        out_cnt++;
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected: output with no sample pending (t=%0t)", $time);
        end else begin
          e = sbq.pop_front();
          chk("sb_re16", longint'(z16_re), e.re16);
          chk("sb_im16", longint'(z16_im), e.im16);
          chk("sb_re34", longint'(z34_re), e.re34);
          chk("sb_im34", longint'(z34_im), e.im34);
          chk("sb_re33", longint'(z33_re), e.re33);
          chk("sb_im33", longint'(z33_im), e.im33);
          chk("sb_last", longint'(m_last), longint'(e.last));
`ifdef COMPLEX_MULT_SAT_EN
          chk("sb_sat", longint'(sat16), longint'(e.sat));
`endif
        end
        if (dir_on && dir_idx < 7) begin
          case (dt[dir_idx].sel)
            0: begin
              chk("dir_re16", longint'(z16_re), dt[dir_idx].er);
              chk("dir_im16", longint'(z16_im), dt[dir_idx].ei);
`ifdef COMPLEX_MULT_SAT_EN
              chk("dir_sat", longint'(sat16), longint'(dt[dir_idx].es));
`endif
            end
            1: begin
              chk("dir_re34", longint'(z34_re), dt[dir_idx].er);
              chk("dir_im34", longint'(z34_im), dt[dir_idx].ei);
            end
            default: begin
              chk("dir_re33", longint'(z33_re), dt[dir_idx].er);
              chk("dir_im33", longint'(z33_im), dt[dir_idx].ei);
            end
          endcase
          out_cyc[dir_idx] = cyc;
          dir_idx++;
        end
      end
      if (s_valid && s_ready)
        sbq.push_back(model(longint'(a_re), longint'(a_im), longint'(b_re),
                            longint'(b_im), s_conj, s_last));
    end
  end

  // Present one sample and hold it until accepted; call just after posedge.
  task automatic send(input logic signed [15:0] ar, ai, br, bi, input bit cj, lst);
    a_re = ar; a_im = ai; b_re = br; b_im = bi;
    s_conj = cj; s_last = lst; s_valid = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 200 && !s_ready; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
    end
    if (!s_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: s_ready stuck low (t=%0t)", $time);
    end
    @(posedge clk); #1;
  endtask

  // Single sample into an empty pipe; count edges from accept to m_valid.
  task automatic lat_test(input string nm, input logic signed [15:0] ar, ai, br, bi);
    int lat;
    a_re = ar; a_im = ai; b_re = br; b_im = bi;
    s_conj = 1'b0; s_last = 1'b0; s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!m_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk(nm, lat, 4);
  endtask

  function automatic logic signed [15:0] rnd16();
    case ($urandom_range(0, 7))
      0:       return 16'sh8000;
      1:       return 16'sh7fff;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c0;
    logic signed [15:0] hz;
    bit rnd_on;

    dt[0] = '{0, 16384, 0, 16384, 0, 1'b0, 8192, 0, 1'b0};
    dt[1] = '{1, 3, 4, 1, 2, 1'b0, -5, 10, 1'b0};
    dt[2] = '{1, 3, 4, 1, 2, 1'b1, 11, -2, 1'b0};
    dt[3] = '{2, 3, 0, 1, 0, 1'b0, 2, 0, 1'b0};
    dt[4] = '{2, -3, 0, 1, 0, 1'b0, -1, 0, 1'b0};
    dt[5] = '{2, -1, 0, 1, 0, 1'b0, 0, 0, 1'b0};
    dt[6] = '{0, -32768, 0, -32768, 0, 1'b0, SAT ? 32767 : -32768, 0, SAT};

    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_conj = 1'b0; m_ready = 1'b1;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_m_valid", longint'(m_valid), 0);
    chk("rst_m_last",  longint'(m_last), 0);
    chk("rst_z_re",    longint'(z16_re), 0);
    chk("rst_z_im",    longint'(z16_im), 0);
    chk("rst_s_ready", longint'(s_ready), 1);
    @(posedge clk); #1;

    // Unity scaling and pipeline latency.
    lat_test("latency", 16'sd16384, 16'sd0, 16'sd16384, 16'sd0);
    chk("unity_re", longint'(z16_re), 8192);
    chk("unity_im", longint'(z16_im), 0);
    @(posedge clk); #1;

    // Directed table, streamed back to back.
    dir_on = 1'b1;
    for (int i = 0; i < 7; i++)
      send(16'(dt[i].ar), 16'(dt[i].ai), 16'(dt[i].br), 16'(dt[i].bi), dt[i].conj, 1'b0);
    s_valid = 1'b0;
    for (int k = 0; k < 50 && dir_idx < 7; k++) @(posedge clk);
    #1;
    chk("dir_count", dir_idx, 7);
    chk("mode_b2b",  out_cyc[2] - out_cyc[1], 1);
    dir_on = 1'b0;

    // Backpressure: 10 samples, m_ready low for 5 cycles mid-stream.
    c0 = out_cnt;
    fork
      begin
        for (int i = 0; i < 10; i++)
          send(rnd16(), rnd16(), rnd16(), rnd16(), 1'($urandom), i == 9);
        s_valid = 1'b0;
      end
      begin
        repeat (6) @(posedge clk);
        #1 m_ready = 1'b0;
        @(negedge clk);
        chk("bp_s_ready_drop", longint'(s_ready), 0);
        chk("bp_m_valid", longint'(m_valid), 1);
        hz = z16_re;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("bp_hold_z", longint'(z16_re), longint'(hz));
          chk("bp_hold_s_ready", longint'(s_ready), 0);
        end
        @(posedge clk); #1 m_ready = 1'b1;
      end
    join
    for (int k = 0; k < 50 && sbq.size() != 0; k++) @(posedge clk);
    #1;
    chk("bp_count", out_cnt - c0, 10);

    // Reset with three samples in flight.
    @(posedge clk); #1;
    send(16'sd1000, -16'sd2000, 16'sd300, 16'sd400, 1'b0, 1'b1);
    send(-16'sd5, 16'sd7, 16'sd9, -16'sd11, 1'b1, 1'b0);
    send(16'sd12345, 16'sd23456, -16'sd4321, 16'sd999, 1'b0, 1'b1);
    s_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_m_valid", longint'(m_valid), 0);
    chk("mid_rst_z_re",    longint'(z16_re), 0);
    chk("mid_rst_z_im",    longint'(z16_im), 0);
    chk("mid_rst_m_last",  longint'(m_last), 0);
    c0 = out_cnt;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_rst_no_emit", out_cnt - c0, 0);
    lat_test("latency_after_rst", 16'sd1000, -16'sd2000, 16'sd300, 16'sd400);
    @(posedge clk); #1;

    // Randomized traffic with random gaps and random backpressure.
    rnd_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            s_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
          send(rnd16(), rnd16(), rnd16(), rnd16(), 1'($urandom), 1'($urandom));
        end
        s_valid = 1'b0;
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk); #1;
          m_ready = ($urandom_range(0, 3) != 0);
        end
        m_ready = 1'b1;
      end
    join
    for (int k = 0; k < 100 && sbq.size() != 0; k++) @(posedge clk);
    #1;
    chk("sb_drained", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
